// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the load/store memory access unit:
//   - funct3 size/sign encodings (B, H, W, BU, HU)
//   - FSM state enumeration (IDLE, REQ, WAIT, RESP)
//   - default watchdog TIMEOUT
//   - helpers that classify a request as legal and/or misaligned
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Only the five size/sign codes above are meaningful; everything else errors.
  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational lane steering for the memory access unit.
//   Ports:
//     funct3    in   size/sign code of the access
//     byte_off  in   addr[1:0] of the access
//     st_data   in   right-aligned store data
//     ld_word   in   raw 32-bit word returned by memory
//     be        out  byte enables for the addressed lanes
//     st_wdata  out  store data replicated across all lanes
//     ld_data   out  selected lane, sign/zero extended to 32 bits
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  // Shift the addressed lane down to bit 0; only the low halfword is ever used.
  logic [15:0] lane;
  assign lane = 16'(ld_word >> {byte_off, 3'b000});

  always_comb begin
    be       = 4'b0000;
    st_wdata = st_data;
    ld_data  = '0;
    case (funct3)
      F3_B: begin
        be       = 4'b0001 << byte_off;
        st_wdata = {4{st_data[7:0]}};
        ld_data  = {{24{lane[7]}}, lane[7:0]};
      end
      F3_BU: begin
        be       = 4'b0001 << byte_off;
        st_wdata = {4{st_data[7:0]}};
        ld_data  = {24'h000000, lane[7:0]};
      end
      F3_H: begin
        be       = 4'b0011 << byte_off;
        st_wdata = {2{st_data[15:0]}};
        ld_data  = {{16{lane[15]}}, lane[15:0]};
      end
      F3_HU: begin
        be       = 4'b0011 << byte_off;
        st_wdata = {2{st_data[15:0]}};
        ld_data  = {16'h0000, lane[15:0]};
      end
      F3_W: begin
        be       = 4'b1111;
        st_wdata = st_data;
        ld_data  = ld_word;
      end
      default: begin
        be       = 4'b0000;
        st_wdata = st_data;
        ld_data  = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Single-outstanding load/store unit between the datapath and a
//   request/grant/rvalid memory port, with a watchdog that aborts stuck
//   accesses.
//   Parameter:
//     TIMEOUT      cycles allowed in REQ+WAIT before aborting with an error
//   Datapath side:
//     clk, rst     clock, asynchronous active-low reset
//     req_valid    in   load/store presented
//     req_ready    out  unit idle and able to accept
//     MemRW        in   1 = store, 0 = load
//     funct3       in   size/sign code
//     addr         in   byte address
//     Wr_data      in   right-aligned store data
//     rsp_valid    out  one-cycle completion pulse
//     rsp_err      out  misaligned / illegal / timeout, with rsp_valid
//     rd_data      out  extended load data (0 for stores and errors)
//     stall        out  pipeline stall from accept through rsp_valid
//   Memory side:
//     mem_req/mem_we/mem_addr/mem_be/mem_wdata  out  request (zero when idle)
//     mem_gnt      in   request accepted
//     mem_rvalid   in   read data valid / write acknowledged
//     mem_rdata    in   read word
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRW,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] Wr_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // The counter only has to reach TIMEOUT-1, the last cycle before the abort.
  localparam int unsigned    WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_rw_q, mem_rw_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic        mem_req_q, mem_req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;

  // Lane steering always works from the registered request, so the memory
  // fields cannot move while mem_req is held.
  mem_lane_align u_lane_align (
    .funct3   (funct3_q),
    .byte_off (addr_q[1:0]),
    .st_data  (wr_data_q),
    .ld_word  (mem_rdata),
    .be       (lane_be),
    .st_wdata (lane_wdata),
    .ld_data  (lane_ld)
  );

  // Next-state logic. Completion takes priority over the watchdog when both
  // land on the same cycle, since the memory has already answered.
  always_comb begin
    state_d     = state_q;
    mem_rw_d    = mem_rw_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rd_data_d   = '0;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (req_valid) begin
          mem_rw_d  = MemRW;
          funct3_d  = funct3;
          addr_d    = addr;
          wr_data_d = Wr_data;
          if (f3_legal(funct3) && !f3_misaligned(funct3, addr[1:0])) begin
            state_d   = ST_REQ;
            mem_req_d = 1'b1;
          end else begin
            // Bad requests never reach memory; answer with an error next cycle.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      ST_REQ: begin
        wd_d = wd_q + 1'b1;
        if (mem_gnt && mem_rvalid) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rd_data_d   = mem_rw_q ? 32'h0 : lane_ld;
        end else if (wd_q == WD_LAST) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end
      end

      ST_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (mem_rvalid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rd_data_d   = mem_rw_q ? 32'h0 : lane_ld;
        end else if (wd_q == WD_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        wd_d    = '0;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        wd_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_rw_q    <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_rw_q    <= mem_rw_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);

  // The accept cycle is still IDLE, so stall must follow req_valid there.
  assign stall = rst & ((state_q != ST_IDLE) | req_valid);

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rd_data   = rd_data_q;

  // Every memory-side field is forced to zero whenever no request is held.
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & mem_rw_q;
  assign mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req_q ? lane_be : 4'b0000;
  assign mem_wdata = (mem_req_q & mem_rw_q) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Scoreboard bench: stimulus pushes expected responses (datapath side and
//   memory side) into queues; a memory responder and a response monitor pop
//   and compare independently.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        MemRW;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] Wr_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rd_data;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } rsp_t;

  // mode: 0 normal, 1 never grant (watchdog), 2 grant but never answer (reset abandon)
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    int          mode;
  } memx_t;

  rsp_t  expQ[$];
  memx_t memQ[$];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemRW      (MemRW),
    .funct3     (funct3),
    .addr       (addr),
    .Wr_data    (Wr_data),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rd_data    (rd_data),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int refSize(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic refErr(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = refSize(f3);
    if (sz == 0) return 1'b1;
    return ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] refBe(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int v;
    sz = refSize(f3);
    if (sz == 4) return 4'hF;
    v = ((1 << sz) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] refWdata(input logic rw, input logic [2:0] f3, input logic [31:0] d);
    if (!rw) return 32'h0;
    case (refSize(f3))
      1:       return (d & 32'hFF) * 32'h01010101;
      2:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] refLoad(input logic rw, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] v;
    if (rw) return 32'h0;
    sh = rd >> (8 * (a % 4));
    case (refSize(f3))
      1: begin
        v = sh & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFFFF00;
      end
      2: begin
        v = sh & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    checkOutput({tag, "_rd_data"},   rd_data,        32'd0);
    checkOutput({tag, "_stall"},     32'(stall),     32'd0);
    checkOutput({tag, "_mem_req"},   32'(mem_req),   32'd0);
    checkOutput({tag, "_mem_we"},    32'(mem_we),    32'd0);
    checkOutput({tag, "_mem_be"},    32'(mem_be),    32'd0);
    checkOutput({tag, "_mem_addr"},  mem_addr,       32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata,      32'd0);
  endtask

  task automatic waitIdle();
    int g = 0;
    while ((expQ.size() != 0 || memQ.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL wait_idle: %0d responses and %0d memory accesses still pending",
               expQ.size(), memQ.size());
    end
  endtask

  // Issue one request: compute expectations, queue them, then drive it.
  task automatic applyStimulus(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input int gdly, input int rdly, input int mode);
    int    g = 0;
    rsp_t  r;
    memx_t m;
    logic  err;
    @(negedge clk);
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL req_ready_wait: got 0, expected 1");
      return;
    end
    err     = refErr(f3, a);
    m.we    = rw;
    m.addr  = a & 32'hFFFFFFFC;
    m.be    = refBe(f3, a);
    m.wdata = refWdata(rw, f3, wd);
    m.rdata = rd;
    m.gdly  = gdly;
    m.rdly  = rdly;
    m.mode  = mode;
    r.acc   = cyc;
    if (mode == 1) begin
      r.err = 1'b1; r.rdata = 32'h0; r.lat = TO + 1;
      expQ.push_back(r);
      memQ.push_back(m);
    end else if (mode == 2) begin
      memQ.push_back(m);
    end else begin
      r.err   = err;
      r.rdata = err ? 32'h0 : refLoad(rw, f3, a, rd);
      r.lat   = err ? 1 : 2 + gdly + rdly;
      expQ.push_back(r);
      if (!err) memQ.push_back(m);
    end
    MemRW     = rw;
    funct3    = f3;
    addr      = a;
    Wr_data   = wd;
    req_valid = 1'b1;
    #1;
    checkOutput("stall_on_accept", 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    MemRW     = 1'($urandom);
    funct3    = 3'($urandom);
    addr      = $urandom;
    Wr_data   = $urandom;
  endtask

  // Response monitor: every rsp_valid must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst && rsp_valid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 rd_data=0x%08h, expected no response", rd_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        checkOutput("rd_data", rd_data, e.rdata);
        checkOutput("stall_at_rsp", 32'(stall), 32'd1);
        checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Memory responder: checks the request fields and answers with the
  // grant/rvalid timing queued by the stimulus.
  initial begin
    memx_t m;
    int    cnt;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && mem_req) begin
        if (memQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_mem_req: got mem_req=1 addr=0x%08h, expected no request", mem_addr);
        end else begin
          m = memQ.pop_front();
          checkOutput("mem_we",    32'(mem_we), 32'(m.we));
          checkOutput("mem_addr",  mem_addr,    m.addr);
          checkOutput("mem_be",    32'(mem_be), 32'(m.be));
          checkOutput("mem_wdata", mem_wdata,   m.wdata);
          if (m.mode == 1) begin
            cnt = 1;
            while (mem_req && cnt < 40) begin
              @(negedge clk);
              if (mem_req) cnt++;
            end
            checkOutput("timeout_req_cycles", 32'(cnt), 32'(TO));
            // Stray handshake after the abort must be ignored.
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            repeat (2) @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
          end else begin
            repeat (m.gdly) @(negedge clk);
            checkOutput("mem_addr_hold", mem_addr, m.addr);
            mem_gnt = 1'b1;
            if (m.rdly == 0 && m.mode == 0) begin
              mem_rvalid = 1'b1;
              mem_rdata  = m.rdata;
            end
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            checkOutput("mem_addr_after_gnt", mem_addr, 32'h0);
            if (m.mode == 0 && m.rdly > 0) begin
              repeat (m.rdly - 1) @(negedge clk);
              mem_rvalid = 1'b1;
              mem_rdata  = m.rdata;
              @(negedge clk);
              mem_rvalid = 1'b0;
              mem_rdata  = $urandom;
            end
          end
        end
      end
    end
  end

  // Main stimulus: reset, directed cases, then randomized traffic.
  initial begin
    int          r;
    logic [2:0]  f3;
    logic        rw;
    logic [31:0] a;
    rst       = 1'b0;
    req_valid = 1'b0;
    MemRW     = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    Wr_data   = 32'h0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
    applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80112233, 0, 1, 0);
    applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80112233, 0, 1, 0);
    applyStimulus(1'b1, 3'b001, 32'h0000_00A2, 32'h0000ABCD, 32'h0, 0, 1, 0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 1, 0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0042, 32'h0, 32'h8001F00F, 0, 0, 0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);
    waitIdle();

    applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 0, 0, 1);
    waitIdle();
    repeat (4) @(negedge clk);

    applyStimulus(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h12345678, 0, 1, 2);
    @(negedge clk);
    checkOutput("in_wait_stall", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1 checkResetOutputs("rst_in_wait");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("ready_after_rst", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFEF00D, 0, 1, 0);
    waitIdle();

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    f3 = 3'd0;
        2, 3:    f3 = 3'd1;
        4, 5:    f3 = 3'd2;
        6:       f3 = 3'd4;
        7:       f3 = 3'd5;
        8:       f3 = 3'd3;
        default: f3 = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
      endcase
      rw = 1'($urandom);
      a  = $urandom;
      applyStimulus(rw, f3, a, $urandom, $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 1), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitIdle();
    repeat (3) @(negedge clk);

    checkOutput("queues_empty", 32'(expQ.size() + memQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
